// File: rtl/dcache_pkg.sv
// Shared types and default sizes for the dcache line flush/fill engine.
// Holds the engine state enum, line geometry defaults and an offset helper.
package dcache_pkg;

  localparam int DEF_DATABITS      = 32;
  localparam int DEF_CACHEADDRBITS = 5;
  localparam int DEF_ADDRBITS      = 32;

  localparam int LINEWORDS = 2 ** DEF_CACHEADDRBITS;
  localparam int WORDBYTES = DEF_DATABITS / 8;

  typedef enum logic [2:0] {
    IDLE,
    WB_RD,
    WB_WR,
    FILL_REQ,
    FILL_DATA,
    DONE
  } state_t;

  // Byte-offset bits covered by one line.
  function automatic int off_bits(int cab, int db);
    return cab + $clog2(db / 8);
  endfunction

endpackage

// File: rtl/dcache_line_fill_if.sv
// Main-memory request/response bus between the line engine and the arbiter.
// master: engine (drives addr/rdreq/wrreq/wrdata); slave: memory side.
interface dcache_line_fill_if
  import dcache_pkg::*;
#(
  parameter int DATABITS = DEF_DATABITS,
  parameter int ADDRBITS = DEF_ADDRBITS
);

  logic [ADDRBITS-1:0] mem_addr;
  logic                mem_rdreq;
  logic                mem_wrreq;
  logic [DATABITS-1:0] mem_wrdata;
  logic                mem_ack;
  logic [DATABITS-1:0] mem_rddata;
  logic                mem_rddata_valid;

  modport master (
    output mem_addr,
    output mem_rdreq,
    output mem_wrreq,
    output mem_wrdata,
    input  mem_ack,
    input  mem_rddata,
    input  mem_rddata_valid
  );

  modport slave (
    input  mem_addr,
    input  mem_rdreq,
    input  mem_wrreq,
    input  mem_wrdata,
    output mem_ack,
    output mem_rddata,
    output mem_rddata_valid
  );

endinterface

// File: rtl/dcache_line_cnt.sv
// Word counter for line walks: synchronous clear, increment, last-word flag.
// Ports: clk, reset, clr, inc in; cnt (W bits), last out. Wraps to 0.
module dcache_line_cnt
  import dcache_pkg::*;
#(
  parameter int W = DEF_CACHEADDRBITS
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt,
  output logic         last
);

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (inc) begin
      cnt <= cnt + W'(1);
    end
  end

  assign last = &cnt;

endmodule

// File: rtl/dcache_line_fill.sv
// Line replacement engine: writes the resident memblock line back to main
// memory, then burst-reads the new line into the memblock.
// Ports: clk/reset; miss_req, old_base, new_base, dcache_wrreq, line_miss
// from the controller; busy/done status; flush_* and line_in* drive the
// memblock, memblock_dout reads it; mem is the main-memory bus (master).
// Optional: DCACHE_SKIPCLEAN_EN tracks a dirty bit and skips clean
// writebacks.
module dcache_line_fill
  import dcache_pkg::*;
#(
  parameter int DATABITS      = DEF_DATABITS,
  parameter int CACHEADDRBITS = DEF_CACHEADDRBITS,
  parameter int ADDRBITS      = DEF_ADDRBITS
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     miss_req,
  input  logic [ADDRBITS-1:0]      old_base,
  input  logic [ADDRBITS-1:0]      new_base,
  input  logic                     dcache_wrreq,
  input  logic                     line_miss,
  output logic                     busy,
  output logic                     done,
  output logic                     flush_mode,
  output logic [CACHEADDRBITS-1:0] flush_addr,
  output logic                     flush_write,
  output logic [DATABITS-1:0]      line_in,
  output logic                     line_in_valid,
  input  logic [DATABITS-1:0]      memblock_dout,
  dcache_line_fill_if.master       mem
);

  localparam int OFF = off_bits(CACHEADDRBITS, DATABITS);
  localparam int WSH = $clog2(DATABITS / 8);

  state_t state;
  state_t state_nx;

  logic [ADDRBITS-1:0]      old_q;
  logic [ADDRBITS-1:0]      new_q;
  logic [DATABITS-1:0]      wrdata_q;
  logic                     hold_q;
  logic [CACHEADDRBITS-1:0] cnt;
  logic                     last;
  logic                     start;
  logic                     cnt_inc;
  logic                     skip_wb;
  logic [ADDRBITS-1:0]      word_off;

  assign start = (state == IDLE) && miss_req;

  assign cnt_inc =
    ((state == WB_WR) && mem.mem_ack) ||
    ((state == FILL_DATA) && mem.mem_rddata_valid);

  assign word_off = ADDRBITS'(cnt) << WSH;

  dcache_line_cnt #(
    .W (CACHEADDRBITS)
  ) u_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (start),
    .inc   (cnt_inc),
    .cnt   (cnt),
    .last  (last)
  );

`ifdef DCACHE_SKIPCLEAN_EN
  logic dirty;

  // Only CPU hits outside replacement dirty the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      dirty <= 1'b0;
    end else if (state == DONE) begin
      dirty <= 1'b0;
    end else if (dcache_wrreq && !line_miss &&
                 (state == IDLE)) begin
      dirty <= 1'b1;
    end
  end

  assign skip_wb = !dirty;

  logic unused_lo;
  assign unused_lo = ^{old_base[OFF-1:0],
                       new_base[OFF-1:0]};
`else
  assign skip_wb = 1'b0;

  logic unused_lo;
  assign unused_lo = ^{old_base[OFF-1:0],
                       new_base[OFF-1:0],
                       dcache_wrreq, line_miss};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (miss_req) begin
          state_nx = skip_wb ? FILL_REQ : WB_RD;
        end
      end
      WB_RD: state_nx = WB_WR;
      WB_WR: begin
        if (mem.mem_ack) begin
          state_nx = last ? FILL_REQ : WB_RD;
        end
      end
      FILL_REQ: begin
        if (mem.mem_ack) begin
          state_nx = FILL_DATA;
        end
      end
      FILL_DATA: begin
        if (mem.mem_rddata_valid && last) begin
          state_nx = DONE;
        end
      end
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // memblock_dout is valid in the first WB_WR cycle; it is parked in
  // wrdata_q so the write data cannot move while the ack is pending.
  always_ff @(posedge clk) begin
    if (reset) begin
      old_q    <= '0;
      new_q    <= '0;
      wrdata_q <= '0;
      hold_q   <= 1'b0;
    end else begin
      if (start) begin
        old_q <= {old_base[ADDRBITS-1:OFF], {OFF{1'b0}}};
        new_q <= {new_base[ADDRBITS-1:OFF], {OFF{1'b0}}};
      end
      if ((state == WB_WR) && !hold_q) begin
        wrdata_q <= memblock_dout;
      end
      hold_q <= (state == WB_WR) && !mem.mem_ack;
    end
  end

  always_comb begin
    busy           = (state != IDLE);
    done           = (state == DONE);
    flush_mode     = busy;
    flush_addr     = busy ? cnt : '0;
    flush_write    = (state == FILL_DATA);
    line_in_valid  = flush_write && mem.mem_rddata_valid;
    line_in        = flush_write ? mem.mem_rddata : '0;
    mem.mem_wrreq  = (state == WB_WR);
    mem.mem_rdreq  = (state == FILL_REQ);
    mem.mem_addr   = '0;
    mem.mem_wrdata = '0;
    if (state == WB_WR) begin
      mem.mem_addr   = old_q + word_off;
      mem.mem_wrdata = hold_q ? wrdata_q : memblock_dout;
    end
    if (state == FILL_REQ) begin
      mem.mem_addr = new_q;
    end
  end

endmodule

// File: tb/tb_dcache_line_fill.sv
// Self-checking bench for dcache_line_fill with a memblock and memory model.
// Random data/bases/waits checked against a line-level reference model.
module tb_dcache_line_fill;
  import dcache_pkg::*;

  localparam int LW = LINEWORDS;
`ifdef DCACHE_SKIPCLEAN_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        miss_req;
  logic [31:0] old_base;
  logic [31:0] new_base;
  logic        dcache_wrreq;
  logic        line_miss;
  logic        busy;
  logic        done;
  logic        flush_mode;
  logic [4:0]  flush_addr;
  logic        flush_write;
  logic [31:0] line_in;
  logic        line_in_valid;
  logic [31:0] memblock_dout;

  logic        cpu_we;
  logic [4:0]  cpu_addr;
  logic [31:0] cpu_data;
  logic [31:0] mb [LW];

  int tests = 0;
  int fails = 0;
  logic [31:0] ref_line [LW];
  bit ref_dirty = 1'b0;

  always #5 clk = ~clk;

  dcache_line_fill_if #(.DATABITS(32), .ADDRBITS(32)) mem ();

  dcache_line_fill dut (
    .clk           (clk),
    .reset         (reset),
    .miss_req      (miss_req),
    .old_base      (old_base),
    .new_base      (new_base),
    .dcache_wrreq  (dcache_wrreq),
    .line_miss     (line_miss),
    .busy          (busy),
    .done          (done),
    .flush_mode    (flush_mode),
    .flush_addr    (flush_addr),
    .flush_write   (flush_write),
    .line_in       (line_in),
    .line_in_valid (line_in_valid),
    .memblock_dout (memblock_dout),
    .mem           (mem)
  );

  // memblock: single-port RAM, 1-cycle read latency
  always @(posedge clk) begin
    if (cpu_we) mb[cpu_addr] <= cpu_data;
    else if (flush_write && line_in_valid)
      mb[flush_addr] <= line_in;
    memblock_dout <= mb[flush_mode ? flush_addr : cpu_addr];
  end

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cpu_write(input int a, input logic [31:0] d,
                           input bit lm);
    @(negedge clk);
    cpu_we = !lm;
    cpu_addr = 5'(a);
    cpu_data = d;
    dcache_wrreq = 1'b1;
    line_miss = lm;
    if (!lm) begin
      ref_line[a] = d;
      ref_dirty = 1'b1;
    end
    @(negedge clk);
    cpu_we = 1'b0;
    dcache_wrreq = 1'b0;
    line_miss = 1'b0;
  endtask

  task automatic reset_mid_wb(input logic [31:0] ob);
    int n = 0;
    bit found = 0;
    @(negedge clk);
    old_base = ob;
    new_base = 32'h9000;
    miss_req = 1'b1;
    for (int c = 0; c < 500 && !found; c++) begin
      @(negedge clk);
      miss_req = 1'b0;
      mem.mem_ack = 1'b0;
      if (mem.mem_wrreq) begin
        if (n == 7) found = 1;
        else begin
          mem.mem_ack = 1'b1;
          n++;
        end
      end
    end
    chk("rst_reach_word7", found, 1);
    chk("rst_word7_addr", mem.mem_addr, {ob[31:7], 7'b0} + 28);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_wrreq", mem.mem_wrreq, 0);
    chk("rst_flush_mode", flush_mode, 0);
    chk("rst_cnt", dut.cnt, 0);
    reset = 1'b0;
    ref_dirty = 1'b0;
  endtask

  task automatic do_miss(input logic [31:0] ob,
                         input logic [31:0] nb,
                         input int wword, input int wcyc,
                         input bit gaps);
    logic [31:0] oba, nba, ha, hd, rd_addr, wait_addr, d;
    logic [31:0] waddr[$], wdata[$], fills[$];
    int fa[$];
    int cyc = 0, ndone = 0, both = 0, unstable = 0;
    int hcyc = 0, wleft = 0, bleft = 0, kind = 0;
    int waited = 0, bad;
    bit holding = 0, racked = 0, tog = 0;
    bit exp_wb;
    oba = {ob[31:7], 7'b0};
    nba = {nb[31:7], 7'b0};
    rd_addr = '0;
    wait_addr = '0;
    exp_wb = !SKIP || ref_dirty;
    @(negedge clk);
    old_base = ob;
    new_base = nb;
    miss_req = 1'b1;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      miss_req = 1'b0;
      mem.mem_ack = 1'b0;
      mem.mem_rddata_valid = 1'b0;
      mem.mem_rddata = $urandom;
      if (ndone > 0 && !busy) break;
      if (done) begin
        ndone++;
        miss_req = 1'b1;
      end
      if (mem.mem_rdreq && mem.mem_wrreq) both++;
      if (flush_write && line_in_valid)
        fa.push_back(int'(flush_addr));
      if (kind == 0)
        kind = mem.mem_wrreq ? 1 : (mem.mem_rdreq ? 2 : 0);
      if (mem.mem_wrreq) begin
        if (!holding) begin
          holding = 1;
          ha = mem.mem_addr;
          hd = mem.mem_wrdata;
          hcyc = 0;
          wleft = (waddr.size() == wword) ? wcyc : 0;
        end else if (mem.mem_addr !== ha ||
                     mem.mem_wrdata !== hd) begin
          unstable++;
        end
        hcyc++;
        if (wleft == 0) begin
          mem.mem_ack = 1'b1;
          if (waddr.size() == wword) begin
            waited = hcyc;
            wait_addr = ha;
          end
          waddr.push_back(ha);
          wdata.push_back(hd);
          holding = 0;
        end else begin
          wleft--;
        end
      end else if (mem.mem_rdreq) begin
        rd_addr = mem.mem_addr;
        mem.mem_ack = 1'b1;
        // junk beat in the ack cycle must be dropped
        mem.mem_rddata_valid = 1'b1;
        racked = 1;
        bleft = LW;
      end else if (racked && bleft > 0) begin
        if (!gaps || tog) begin
          d = $urandom;
          mem.mem_rddata = d;
          mem.mem_rddata_valid = 1'b1;
          fills.push_back(d);
          bleft--;
        end
        tog = !tog;
      end
    end
    chk("miss_timeout", cyc < 3000, 1);
    chk("wb_count", waddr.size(), exp_wb ? LW : 0);
    bad = 0;
    foreach (waddr[i])
      if (waddr[i] !== oba + 32'(4 * i) ||
          wdata[i] !== ref_line[i]) bad++;
    chk("wb_addr_data", bad, 0);
    chk("first_req_kind", kind, exp_wb ? 1 : 2);
    chk("rd_addr", rd_addr, nba);
    chk("fill_beats", fa.size(), LW);
    bad = 0;
    foreach (fa[i]) if (fa[i] != i) bad++;
    chk("fill_addr_seq", bad, 0);
    bad = 0;
    foreach (fills[i]) if (mb[i] !== fills[i]) bad++;
    chk("fill_data", bad, 0);
    chk("done_pulses", ndone, 1);
    chk("req_overlap", both, 0);
    chk("req_stable", unstable, 0);
    if (exp_wb && wword < LW) begin
      chk("ack_wait_cycles", waited, wcyc + 1);
      chk("ack_wait_addr", wait_addr,
          oba + 32'(4 * wword));
    end
    @(negedge clk);
    chk("done_miss_ignored", busy, 0);
    foreach (fills[i]) ref_line[i] = fills[i];
    ref_dirty = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    miss_req = 1'b0;
    old_base = '0;
    new_base = '0;
    dcache_wrreq = 1'b0;
    line_miss = 1'b0;
    cpu_we = 1'b0;
    cpu_addr = '0;
    cpu_data = '0;
    mem.mem_ack = 1'b0;
    mem.mem_rddata = '0;
    mem.mem_rddata_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_flush_mode", flush_mode, 0);
    chk("reset_flush_addr", flush_addr, 0);
    chk("reset_flush_write", flush_write, 0);
    chk("reset_line_in_valid", line_in_valid, 0);
    chk("reset_rdreq", mem.mem_rdreq, 0);
    chk("reset_wrreq", mem.mem_wrreq, 0);
    chk("reset_mem_addr", mem.mem_addr, 0);
    chk("reset_wrdata", mem.mem_wrdata, 0);
    reset = 1'b0;

    for (int i = 0; i < LW; i++) cpu_write(i, $urandom, 0);
    reset_mid_wb(32'h1000);

    cpu_write(3, $urandom, 0);
    do_miss(32'h1000, 32'h2000, LW, 0, 0);

    cpu_write(5, $urandom, 0);
    do_miss(32'h1000, 32'h3000, 5, 3, 0);

    do_miss(32'h2000, 32'h4000, LW, 0, 0);

    cpu_write(2, $urandom, 1);
    do_miss(32'h4000, 32'h5000, LW, 0, 0);
    cpu_write(9, $urandom, 0);
    do_miss(32'h5000, 32'h6000, LW, 0, 0);

    cpu_write(0, $urandom, 0);
    do_miss(32'h6000, 32'h7000, LW, 0, 1);

    for (int k = 0; k < 4; k++) begin
      for (int j = 0; j < 3; j++)
        cpu_write($urandom_range(0, LW - 1), $urandom,
                  1'($urandom_range(0, 1)));
      do_miss($urandom, $urandom,
              $urandom_range(0, LW - 1),
              $urandom_range(0, 4),
              1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
